// File: rtl/shared_vc_credit_ctrl_pkg.sv
// Shared definitions for the dynamically shared VC controller: state encoding
// and index helpers used by the controller and its round-robin arbiter.
package shared_vc_credit_ctrl_pkg;

    localparam logic st_idle  = 1'b0;
    localparam logic st_owned = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int flat_idx(input int p, input int v, input int nv);
        return p * nv + v;
    endfunction

endpackage

// File: rtl/shared_vc_credit_ctrl_rr_arbiter.sv
// Round-robin arbiter for one output port; the pointer advances past the
// releasing owner only when upd_en_i is pulsed.
module shared_vc_rr_arbiter
    import shared_vc_credit_ctrl_pkg::*;
#(
    parameter  int num_vcs = 5,
    localparam int ptr_w   = (num_vcs > 1) ? clog2(num_vcs) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [num_vcs-1:0] req_i,
    input  logic               upd_en_i,
    input  logic [num_vcs-1:0] owner_i,
    output logic [num_vcs-1:0] gnt_o
);

    logic [ptr_w-1:0] ptr_q, ptr_d;
    logic [ptr_w-1:0] owner_idx;
    logic [ptr_w-1:0] idx;
    logic [ptr_w:0]   sum;
    logic             found;

    // Search starts at the pointer and wraps modulo num_vcs.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < num_vcs; i++) begin
            sum = {1'b0, ptr_q} + (ptr_w+1)'(i);
            if (sum >= (ptr_w+1)'(num_vcs)) begin
                sum = sum - (ptr_w+1)'(num_vcs);
            end
            idx = sum[ptr_w-1:0];
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < num_vcs; i++) begin
            if (owner_i[i]) begin
                owner_idx = ptr_w'(i);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (upd_en_i) begin
            ptr_d = (owner_idx == ptr_w'(num_vcs - 1)) ? '0 : owner_idx + ptr_w'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/shared_vc_credit_ctrl.sv
// Per-output-port ownership and credit tracking for the downstream shared VC.
// state | meaning:  IDLE | no owner, may grant   OWNED | one VC holds the shared VC until tail
module shared_vc_credit_ctrl
    import shared_vc_credit_ctrl_pkg::*;
#(
    parameter  int num_ports    = 5,
    parameter  int num_vcs      = 5,
    parameter  int shared_depth = 8,
    localparam int cnt_width    = clog2(shared_depth + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [num_ports*num_vcs-1:0]   shared_req_op,
    output logic [num_ports*num_vcs-1:0]   shared_gnt_op,
    input  logic [num_ports-1:0]           flit_valid_op,
    input  logic [num_ports-1:0]           flit_tail_op,
    input  logic [num_ports-1:0]           credit_for_shared_in,
    output logic [num_ports-1:0]           shared_vc_out,
    output logic [num_ports-1:0]           shared_credit_avail_op,
    output logic [num_ports*cnt_width-1:0] credit_count_op,
    output logic                           error
);

    localparam logic [cnt_width-1:0] depth_c = cnt_width'(shared_depth);

    logic [num_ports-1:0] port_err;
    logic                 error_q;

    for (genvar p = 0; p < num_ports; p++) begin : g_port
        logic                 state_q, state_d;
        logic [num_vcs-1:0]   gnt_q, gnt_d, arb_gnt, req;
        logic [cnt_width-1:0] cnt_q, cnt_d;
        logic                 svo_q;
        logic                 upd_en;
        logic                 fv, ft, cr;
        logic                 can_grant;

        assign req       = shared_req_op[flat_idx(p, 0, num_vcs) +: num_vcs];
        assign fv        = flit_valid_op[p];
        assign ft        = flit_tail_op[p];
        assign cr        = credit_for_shared_in[p];
        assign can_grant = (|req) && (cnt_q != '0);

        shared_vc_rr_arbiter #(.num_vcs(num_vcs)) u_arb (
            .clk      (clk),
            .reset    (reset),
            .req_i    (req),
            .upd_en_i (upd_en),
            .owner_i  (gnt_q),
            .gnt_o    (arb_gnt)
        );

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= st_idle;
                gnt_q   <= '0;
                cnt_q   <= depth_c;
                svo_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                gnt_q   <= gnt_d;
                cnt_q   <= cnt_d;
                svo_q   <= fv;
            end
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                st_idle:  if (can_grant) state_d = st_owned;
                default:  if (fv && ft)  state_d = st_idle;
            endcase
        end

        // Release clears the grant without regranting, leaving one IDLE cycle between owners.
        always_comb begin
            gnt_d  = gnt_q;
            upd_en = 1'b0;
            case (state_q)
                st_idle: gnt_d = can_grant ? arb_gnt : '0;
                default: begin
                    if (fv && ft) begin
                        gnt_d  = '0;
                        upd_en = 1'b1;
                    end
                end
            endcase
        end

        always_comb begin
            cnt_d       = cnt_q;
            port_err[p] = fv && (state_q == st_idle);
            if (fv && !cr) begin
                if (cnt_q == '0) port_err[p] = 1'b1;
                else             cnt_d = cnt_q - cnt_width'(1);
            end else if (cr && !fv) begin
                if (cnt_q == depth_c) port_err[p] = 1'b1;
                else                  cnt_d = cnt_q + cnt_width'(1);
            end
        end

        assign shared_gnt_op[flat_idx(p, 0, num_vcs) +: num_vcs] = gnt_q;
        assign shared_vc_out[p]                                  = svo_q;
        assign shared_credit_avail_op[p]                         = (cnt_q != '0);
        assign credit_count_op[p*cnt_width +: cnt_width]         = cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_q | (|port_err);
        end
    end

    assign error = error_q;

endmodule

// File: tb/tb_shared_vc_credit_ctrl.sv
// Bench for shared_vc_credit_ctrl: directed scenarios plus randomized traffic
// checked against a per-port owner/pointer/credit reference model.
module tb_shared_vc_credit_ctrl;

    localparam int NP = 5;
    localparam int NV = 5;
    localparam int D  = 8;
    localparam int CW = 4;

    logic              clk;
    logic              reset;
    logic [NP*NV-1:0]  req;
    logic [NP*NV-1:0]  gnt;
    logic [NP-1:0]     fv, ft, cr;
    logic [NP-1:0]     svo, avail;
    logic [NP*CW-1:0]  cnt;
    logic              err;

    int errors = 0;
    int checks = 0;

    int m_owner[NP];
    int m_ptr[NP];
    int m_cnt[NP];
    bit m_svo[NP];
    bit m_err;

    shared_vc_credit_ctrl #(.num_ports(NP), .num_vcs(NV), .shared_depth(D)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .shared_req_op          (req),
        .shared_gnt_op          (gnt),
        .flit_valid_op          (fv),
        .flit_tail_op           (ft),
        .credit_for_shared_in   (cr),
        .shared_vc_out          (svo),
        .shared_credit_avail_op (avail),
        .credit_count_op        (cnt),
        .error                  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NV-1:0] gnt_of(input int p);
        return gnt[p*NV +: NV];
    endfunction

    function automatic int cnt_of(input int p);
        return int'(cnt[p*CW +: CW]);
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_owner[p] = -1;
            m_ptr[p]   = 0;
            m_cnt[p]   = D;
            m_svo[p]   = 0;
        end
        m_err = 0;
    endtask

    // Applies the current inputs for one clock to the model.
    task automatic model_step();
        for (int p = 0; p < NP; p++) begin
            int win;
            win = -1;
            if (m_owner[p] < 0) begin
                if (m_cnt[p] > 0) begin
                    for (int k = 0; k < NV; k++) begin
                        int v;
                        v = (m_ptr[p] + k) % NV;
                        if (win < 0 && req[p*NV + v]) win = v;
                    end
                end
                if (fv[p]) m_err = 1;
                m_owner[p] = win;
            end else if (fv[p] && ft[p]) begin
                m_ptr[p]   = (m_owner[p] + 1) % NV;
                m_owner[p] = -1;
            end
            if (fv[p] && !cr[p]) begin
                if (m_cnt[p] == 0) m_err = 1;
                else               m_cnt[p] = m_cnt[p] - 1;
            end else if (cr[p] && !fv[p]) begin
                if (m_cnt[p] == D) m_err = 1;
                else               m_cnt[p] = m_cnt[p] + 1;
            end
            m_svo[p] = fv[p];
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req = '0;
        fv  = '0;
        ft  = '0;
        cr  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) tick();
        for (int p = 0; p < NP; p++) begin
            checks++;
            if (cnt_of(p) !== D) begin
                errors++;
                $display("FAIL reset_count p%0d: got %0d expected %0d", p, cnt_of(p), D);
            end
        end
        checks++;
        if (avail !== 5'b11111) begin
            errors++;
            $display("FAIL reset_avail: got %b expected 11111", avail);
        end
        checks++;
        if (gnt !== '0) begin
            errors++;
            $display("FAIL reset_gnt: got %h expected 0", gnt);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL reset_error: got %b expected 0", err);
        end
        checks++;
        if (svo !== '0) begin
            errors++;
            $display("FAIL reset_svo: got %b expected 0", svo);
        end
    endtask

    task automatic test_port0_packet();
        int exp_cnt[3] = '{7, 6, 5};
        do_reset();
        req[1] = 1'b1;
        req[3] = 1'b1;
        tick();
        checks++;
        if (gnt_of(0) !== 5'b00010) begin
            errors++;
            $display("FAIL p0_first_gnt: got %b expected 00010", gnt_of(0));
        end
        fv[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ft[0] = (i == 2);
            tick();
            checks++;
            if (cnt_of(0) !== exp_cnt[i]) begin
                errors++;
                $display("FAIL p0_count flit%0d: got %0d expected %0d", i, cnt_of(0), exp_cnt[i]);
            end
            checks++;
            if (svo[0] !== 1'b1) begin
                errors++;
                $display("FAIL p0_svo flit%0d: got %b expected 1", i, svo[0]);
            end
        end
        checks++;
        if (gnt_of(0) !== 5'b00000) begin
            errors++;
            $display("FAIL p0_release_gnt: got %b expected 00000", gnt_of(0));
        end
        fv[0] = 1'b0;
        ft[0] = 1'b0;
        tick();
        checks++;
        if (gnt_of(0) !== 5'b01000) begin
            errors++;
            $display("FAIL p0_second_gnt: got %b expected 01000", gnt_of(0));
        end
        checks++;
        if (svo[0] !== 1'b0) begin
            errors++;
            $display("FAIL p0_svo_idle: got %b expected 0", svo[0]);
        end
        req   = '0;
        cr[0] = 1'b1;
        tick();
        tick();
        cr[0] = 1'b0;
        tick();
        checks++;
        if (cnt_of(0) !== 7) begin
            errors++;
            $display("FAIL p0_final_count: got %0d expected 7", cnt_of(0));
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL p0_error: got %b expected 0", err);
        end
    endtask

    task automatic test_credit_starve();
        do_reset();
        req[2*NV + 0] = 1'b1;
        tick();
        fv[2] = 1'b1;
        repeat (D - 1) tick();
        ft[2] = 1'b1;
        tick();
        fv[2] = 1'b0;
        ft[2] = 1'b0;
        checks++;
        if (cnt_of(2) !== 0 || avail[2] !== 1'b0) begin
            errors++;
            $display("FAIL p2_drained: got count %0d avail %b expected 0 0", cnt_of(2), avail[2]);
        end
        req[2*NV + 1] = 1'b1;
        repeat (3) tick();
        checks++;
        if (gnt_of(2) !== 5'b00000) begin
            errors++;
            $display("FAIL p2_no_gnt_at_zero: got %b expected 00000", gnt_of(2));
        end
        cr[2] = 1'b1;
        tick();
        cr[2] = 1'b0;
        checks++;
        if (cnt_of(2) !== 1 || gnt_of(2) !== 5'b00000) begin
            errors++;
            $display("FAIL p2_credit_back: got count %0d gnt %b expected 1 00000", cnt_of(2), gnt_of(2));
        end
        tick();
        checks++;
        if (gnt_of(2) !== 5'b00010) begin
            errors++;
            $display("FAIL p2_regrant: got %b expected 00010", gnt_of(2));
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL p2_error: got %b expected 0", err);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        req[4*NV + 0] = 1'b1;
        tick();
        fv[4] = 1'b1;
        repeat (3) tick();
        checks++;
        if (cnt_of(4) !== 5) begin
            errors++;
            $display("FAIL p4_setup_count: got %0d expected 5", cnt_of(4));
        end
        cr[4] = 1'b1;
        tick();
        fv[4] = 1'b0;
        cr[4] = 1'b0;
        checks++;
        if (cnt_of(4) !== 5) begin
            errors++;
            $display("FAIL p4_same_cycle_count: got %0d expected 5", cnt_of(4));
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL p4_same_cycle_error: got %b expected 0", err);
        end
    endtask

    task automatic test_errors();
        do_reset();
        cr[1] = 1'b1;
        tick();
        cr[1] = 1'b0;
        checks++;
        if (cnt_of(1) !== D || err !== 1'b1) begin
            errors++;
            $display("FAIL overflow: got count %0d error %b expected %0d 1", cnt_of(1), err, D);
        end
        repeat (4) tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL error_sticky: got %b expected 1", err);
        end
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL error_cleared: got %b expected 0", err);
        end
        fv[3] = 1'b1;
        tick();
        fv[3] = 1'b0;
        checks++;
        if (err !== 1'b1 || cnt_of(3) !== D - 1 || gnt_of(3) !== 5'b00000) begin
            errors++;
            $display("FAIL illegal_send: got error %b count %0d gnt %b expected 1 %0d 00000",
                     err, cnt_of(3), gnt_of(3), D - 1);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        req[3] = 1'b1;
        tick();
        fv[0] = 1'b1;
        ft[0] = 1'b1;
        tick();
        fv[0] = 1'b0;
        ft[0] = 1'b0;
        req   = '0;
        req[1] = 1'b1;
        tick();
        checks++;
        if (gnt_of(0) !== 5'b00010) begin
            errors++;
            $display("FAIL mid_setup_gnt: got %b expected 00010", gnt_of(0));
        end
        fv[0] = 1'b1;
        repeat (4) tick();
        fv[0] = 1'b0;
        checks++;
        if (cnt_of(0) !== 3) begin
            errors++;
            $display("FAIL mid_setup_count: got %0d expected 3", cnt_of(0));
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (gnt_of(0) !== 5'b00000 || cnt_of(0) !== D) begin
            errors++;
            $display("FAIL async_reset: got gnt %b count %0d expected 00000 %0d", gnt_of(0), cnt_of(0), D);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        req    = '0;
        req[0] = 1'b1;
        req[4] = 1'b1;
        tick();
        checks++;
        if (gnt_of(0) !== 5'b00001) begin
            errors++;
            $display("FAIL rr_restart: got %b expected 00001", gnt_of(0));
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc % 250 == 249) do_reset();
            for (int p = 0; p < NP; p++) begin
                for (int v = 0; v < NV; v++) req[p*NV + v] = ($urandom % 4 == 0);
                fv[p] = (m_owner[p] >= 0) ? ($urandom % 3 != 0) : ($urandom % 25 == 0);
                ft[p] = ($urandom % 4 == 0);
                cr[p] = ($urandom % 3 == 0);
            end
            tick();
            for (int p = 0; p < NP; p++) begin
                logic [NV-1:0] eg;
                eg = '0;
                if (m_owner[p] >= 0) eg[m_owner[p]] = 1'b1;
                checks++;
                if (gnt_of(p) !== eg) begin
                    errors++;
                    $display("FAIL rand_gnt c%0d p%0d: got %b expected %b", cyc, p, gnt_of(p), eg);
                end
                checks++;
                if (cnt_of(p) !== m_cnt[p]) begin
                    errors++;
                    $display("FAIL rand_count c%0d p%0d: got %0d expected %0d", cyc, p, cnt_of(p), m_cnt[p]);
                end
                checks++;
                if (avail[p] !== (m_cnt[p] > 0)) begin
                    errors++;
                    $display("FAIL rand_avail c%0d p%0d: got %b expected %b", cyc, p, avail[p], m_cnt[p] > 0);
                end
                checks++;
                if (svo[p] !== m_svo[p]) begin
                    errors++;
                    $display("FAIL rand_svo c%0d p%0d: got %b expected %b", cyc, p, svo[p], m_svo[p]);
                end
            end
            checks++;
            if (err !== m_err) begin
                errors++;
                $display("FAIL rand_error c%0d: got %b expected %b", cyc, err, m_err);
            end
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        model_reset();
        test_reset();
        test_port0_packet();
        test_credit_starve();
        test_same_cycle();
        test_errors();
        test_reset_mid_packet();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
